// File: rtl/x_arb_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
// Requester count, ID width, FSM state type and grant encode/decode helpers.
package x_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [ID_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/x_rr_arb16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface x_rr_arb16_if;
    import x_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               lock;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;
    logic               any_req;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  any_req
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output any_req
    );

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: lowest request at or above the pointer,
// falling back to the lowest request overall when nothing sits above it.
module rr_pick16
    import x_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_pick,
    output logic               o_found
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_masked;

    function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Masked priority encode with unmasked fallback; found doubles as ANY_REQ.
    always_comb begin
        w_mask   = {NUM_REQ{1'b1}} << i_ptr;
        w_masked = i_req & w_mask;
        o_found  = |i_req;
        if (|w_masked) begin
            o_pick = prio_enc(w_masked);
        end else begin
            o_pick = prio_enc(i_req);
        end
    end

endmodule

// File: rtl/x_rr_arb16_chk.sv
// Grant-invariant checker for x_rr_arb16; attach alongside any instance.
module x_rr_arb16_chk
    import x_arb_pkg::*;
(
    input logic               i_clk,
    input logic               i_rst,
    input logic [NUM_REQ-1:0] i_gnt,
    input logic [ID_W-1:0]    i_gnt_id,
    input logic               i_gnt_vld
);

    a_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(i_gnt));

    a_vld: assert property (@(posedge i_clk) disable iff (i_rst)
        i_gnt_vld == (|i_gnt));

    a_id: assert property (@(posedge i_clk) disable iff (i_rst)
        !i_gnt_vld || (i_gnt_id == onehot_to_idx(i_gnt)));

    a_idle_id: assert property (@(posedge i_clk) disable iff (i_rst)
        i_gnt_vld || (i_gnt_id == {ID_W{1'b0}}));

endmodule

// File: rtl/x_rr_arb16.sv
// 16-requester round-robin arbiter with hold, lock and bounded-tenure preemption.
// Grant, grant ID and valid are registered; ANY_REQ is the combinational wide OR.
module x_rr_arb16
    import x_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    x_rr_arb16_if.slave io_arb
);

    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W:0]   HOLD_LIMIT = (CNT_W+1)'(MAX_HOLD);
    localparam logic             PREEMPT_EN = (MAX_HOLD != 0);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    w_gnt_id_nxt;
    logic               r_gnt_vld;
    logic               w_gnt_vld_nxt;

    logic [ID_W-1:0]    w_pick;
    logic               w_found;
    logic               w_owner_req;
    logic               w_others;
    logic               w_tenure_up;
    logic               w_preempt;
    logic               w_load;
    logic               w_clear;

    rr_pick16 u_pick (
        .i_req   (io_arb.req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    // Owner status and the preemption condition for the current tenure.
    always_comb begin
        w_owner_req = io_arb.req[r_gnt_id];
        w_others    = |(io_arb.req & ~r_gnt);
        // CNT counts from 0, so the tenure is used up once CNT+1 reaches MAX_HOLD.
        w_tenure_up = (({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= HOLD_LIMIT);
        w_preempt   = PREEMPT_EN && w_tenure_up && !io_arb.lock && w_others;
    end

    // Next-state decision: load a new pick, clear to idle, or hold the owner.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load = 1'b1;
                end else begin
                    w_clear = 1'b1;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear = 1'b1;
                    end
                end else if (w_preempt) begin
                    w_load = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    // Next register values derived from the decision above.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_vld_nxt = r_gnt_vld;
        if (w_load) begin
            w_state_nxt   = GRANT;
            w_gnt_nxt     = idx_to_onehot(w_pick);
            w_gnt_id_nxt  = w_pick;
            w_gnt_vld_nxt = 1'b1;
            w_ptr_nxt     = w_pick + {{(ID_W-1){1'b0}}, 1'b1};
            w_cnt_nxt     = {CNT_W{1'b0}};
        end else if (w_clear) begin
            w_state_nxt   = IDLE;
            w_gnt_nxt     = {NUM_REQ{1'b0}};
            w_gnt_id_nxt  = {ID_W{1'b0}};
            w_gnt_vld_nxt = 1'b0;
            w_cnt_nxt     = {CNT_W{1'b0}};
        end else if (r_cnt != HOLD_MAX) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= {ID_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_gnt     <= {NUM_REQ{1'b0}};
            r_gnt_id  <= {ID_W{1'b0}};
            r_gnt_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
        end
    end

    assign io_arb.gnt     = r_gnt;
    assign io_arb.gnt_id  = r_gnt_id;
    assign io_arb.gnt_vld = r_gnt_vld;
    assign io_arb.any_req = w_found;

endmodule

// File: tb/tb_x_rr_arb16.sv
// Directed bench for x_rr_arb16: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share stimulus and are compared every cycle to an abstract arbitration model.
module tb_x_rr_arb16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        lock = 1'b0;
    bit          chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    x_rr_arb16_if if4 ();
    x_rr_arb16_if if1 ();

    assign if4.req  = req;
    assign if4.lock = lock;
    assign if1.req  = req;
    assign if1.lock = lock;

    x_rr_arb16 #(.MAX_HOLD(4), .CNT_W(5)) dut4 (.i_clk(clk), .i_rst(rst), .io_arb(if4));
    x_rr_arb16 #(.MAX_HOLD(1), .CNT_W(5)) dut1 (.i_clk(clk), .i_rst(rst), .io_arb(if1));

    x_rr_arb16_chk chk4 (.i_clk(clk), .i_rst(rst), .i_gnt(if4.gnt),
                         .i_gnt_id(if4.gnt_id), .i_gnt_vld(if4.gnt_vld));
    x_rr_arb16_chk chk1 (.i_clk(clk), .i_rst(rst), .i_gnt(if1.gnt),
                         .i_gnt_id(if1.gnt_id), .i_gnt_vld(if1.gnt_vld));

    always #5 clk = ~clk;

    // Model: owner (-1 = idle), next-priority index, cycles the owner has held.
    int mh[2]   = '{4, 1};
    int own[2]  = '{-1, -1};
    int mptr[2] = '{0, 0};
    int held[2] = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic grant(input int k, input int p);
        own[k]  = p;
        mptr[k] = (p + 1) % 16;
        held[k] = 1;
    endtask

    task automatic model_step(input int k);
        int p;
        logic [15:0] oth;
        if (rst) begin
            own[k] = -1; mptr[k] = 0; held[k] = 0;
        end else if (own[k] < 0) begin
            p = pick(req, mptr[k]);
            if (p >= 0) grant(k, p);
        end else if (!req[own[k]]) begin
            p = pick(req, mptr[k]);
            if (p >= 0) grant(k, p);
            else own[k] = -1;
        end else begin
            oth = req;
            oth[own[k]] = 1'b0;
            if (mh[k] != 0 && held[k] >= mh[k] && !lock && oth != 16'h0000)
                grant(k, pick(req, mptr[k]));
            else
                held[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic cmp(input int k, input logic [15:0] g, input logic [3:0] id,
                       input logic v, input logic a, input logic [3:0] p);
        logic [15:0] eg;
        eg = 16'h0000;
        if (own[k] >= 0) eg[own[k]] = 1'b1;
        chk($sformatf("model_gnt[%0d]", k), 32'(g), 32'(eg));
        chk($sformatf("model_id[%0d]", k), 32'(id), (own[k] < 0) ? 32'd0 : 32'(own[k]));
        chk($sformatf("model_vld[%0d]", k), 32'(v), (own[k] >= 0) ? 32'd1 : 32'd0);
        chk($sformatf("model_any[%0d]", k), 32'(a), 32'(|req));
        chk($sformatf("model_ptr[%0d]", k), 32'(p), 32'(mptr[k]));
    endtask

    // Per-cycle comparison, sampled well after the edge and before the next drive.
    always @(posedge clk) begin
        #4;
        if (chk_en) begin
            cmp(0, if4.gnt, if4.gnt_id, if4.gnt_vld, if4.any_req, dut4.r_ptr);
            cmp(1, if1.gnt, if1.gnt_id, if1.gnt_vld, if1.any_req, dut1.r_ptr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("reset_gnt", 32'(if4.gnt), 32'h0000);
        chk("reset_vld", 32'(if4.gnt_vld), 32'd0);
        chk("reset_id", 32'(if4.gnt_id), 32'd0);
        chk("reset_ptr", 32'(dut4.r_ptr), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        cyc(10);
        chk("idle_any", 32'(if4.any_req), 32'd0);
        chk("idle_gnt", 32'(if4.gnt), 32'h0000);

        req = 16'h0020;
        cyc(1);
        chk("single_gnt", 32'(if4.gnt), 32'h0020);
        chk("single_id", 32'(if4.gnt_id), 32'd5);
        cyc(3);
        chk("single_hold", 32'(if4.gnt), 32'h0020);
        req = 16'h0000;
        cyc(1);
        chk("single_drop_gnt", 32'(if4.gnt), 32'h0000);
        chk("single_drop_ptr", 32'(dut4.r_ptr), 32'd6);

        req = 16'h0020;
        cyc(1);
        chk("rst_pre_gnt", 32'(if4.gnt), 32'h0020);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_gnt", 32'(if4.gnt), 32'h0000);
        chk("rst_mid_ptr", 32'(dut4.r_ptr), 32'd0);
        rst = 1'b0;
        req = 16'h0000;
        cyc(1);

        req = 16'h8001;
        cyc(1);
        chk("handoff_first", 32'(if4.gnt), 32'h0001);
        req = 16'h8000;
        cyc(1);
        chk("handoff_gnt", 32'(if4.gnt), 32'h8000);
        chk("handoff_id", 32'(if4.gnt_id), 32'd15);
        chk("handoff_vld", 32'(if4.gnt_vld), 32'd1);
        chk("handoff_ptr", 32'(dut4.r_ptr), 32'd0);
        req = 16'h0000;
        cyc(1);

        req = 16'h0003;
        for (int c = 0; c < 9; c++) begin
            cyc(1);
            chk($sformatf("preempt_id_c%0d", c), 32'(if4.gnt_id), 32'((c / 4) % 2));
        end
        lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk($sformatf("lock_id_c%0d", c), 32'(if4.gnt_id), 32'd0);
        end
        chk("lock_cnt_sat", 32'(dut4.r_cnt), 32'd4);
        lock = 1'b0;
        cyc(1);
        chk("unlock_id", 32'(if4.gnt_id), 32'd1);
        req = 16'h0000;
        cyc(2);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 16'hFFFF;
        for (int c = 0; c < 17; c++) begin
            cyc(1);
            chk($sformatf("rotate_id_c%0d", c), 32'(if1.gnt_id), 32'(c % 16));
            chk($sformatf("rotate_gnt_c%0d", c), 32'(if1.gnt), 32'(16'h0001 << (c % 16)));
        end
        req = 16'h0000;
        cyc(1);

        req = 16'h2000;
        cyc(1);
        chk("wrap_pre_id", 32'(if4.gnt_id), 32'd13);
        chk("wrap_pre_ptr", 32'(dut4.r_ptr), 32'd14);
        req = 16'h0005;
        cyc(1);
        chk("wrap_id", 32'(if4.gnt_id), 32'd0);
        chk("wrap_ptr", 32'(dut4.r_ptr), 32'd1);
        chk("wrap_id_h1", 32'(if1.gnt_id), 32'd0);
        req = 16'h0000;
        cyc(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x_rr_arb16.md
Name: x_rr_arb16

Overview:
- 16-requester round-robin arbiter sharing one downstream resource (bus, port, LUT slice) between up to 16 sources.
- Produces the wide-OR "any request" term (same reduction as the 16-input OR primitive), a registered one-hot grant and an encoded grant ID.
- Sits between requester logic and the shared datapath mux, which it selects via GNT_ID.
- Supports grant hold, lock and a bounded-tenure preemption timer.

Parameters:
- MAX_HOLD, 16, max consecutive grant cycles before preemption when others wait; 0 = preemption disabled.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  in  1  rising-edge clock, single clock domain
- RST  in  1  synchronous, active-high reset
- REQ  in  16  request vector, bit i = requester i; held high until done
- LOCK  in  1  from current owner: when high with its REQ, blocks preemption
- GNT  out  16  registered one-hot grant; all-zero when idle
- GNT_ID  out  4  registered binary index of the granted requester
- GNT_VLD  out  1  registered; high iff GNT non-zero
- ANY_REQ  out  1  combinational OR of REQ[15:0]

Behaviour:
- Reset, sampled on CLK edge while RST=1:
  - GNT=0, GNT_ID=0, GNT_VLD=0.
  - Priority pointer PTR=0, hold counter CNT=0, state IDLE.
  - RST overrides all other inputs. RST asserted mid-grant drops GNT on that same edge.
- Pick function: first i in circular order PTR, PTR+1, …, 15, 0, …, PTR-1 with REQ[i]=1. Index arithmetic is mod 16.
- State IDLE:
  - If ANY_REQ: next edge loads GNT=onehot(pick), GNT_ID=pick, GNT_VLD=1, PTR=pick+1 mod 16, CNT=0 → GRANT.
  - Latency: REQ to GNT is 1 cycle.
  - Otherwise stay IDLE with outputs 0.
- State GRANT, owner o=GNT_ID:
  - Release: REQ[o]=0. If other requests are pending, grant pick directly on the next edge with no idle bubble, and update PTR and CNT=0 as above. If none are pending, clear outputs → IDLE.
  - Hold: REQ[o]=1 and no preempt → keep grant; CNT increments, saturating at MAX_HOLD.
  - Preempt condition: MAX_HOLD≠0, CNT≥MAX_HOLD-1, LOCK=0, and some REQ[j]=1 with j≠o. On the next edge, grant pick, which excludes o because PTR=o+1. Set CNT=0. The preempted requester keeps REQ high and re-competes normally.
  - LOCK=1 with REQ[o]=1 suppresses preemption indefinitely; CNT still saturates. LOCK is ignored in IDLE and when REQ[o]=0.
  - With no other requesters pending, the owner keeps the grant beyond MAX_HOLD.
- Simultaneous events:
  - Owner release coinciding with a preempt condition is treated as a release.
  - A new REQ arriving in the same cycle as a release is eligible in that pick.
- Invariants:
  - GNT is always one-hot or zero.
  - GNT_VLD equals |GNT.
  - GNT_ID matches GNT whenever GNT_VLD=1.
  - GNT never changes except on a CLK edge.
- Fairness: with all 16 requesting continuously and MAX_HOLD=1, grants rotate 0,1,…,15,0 at one requester per cycle.

Decomposition:
- Shared package x_arb_pkg:
  - NUM_REQ=16, ID_W=4.
  - State enum {IDLE, GRANT}.
  - onehot-to-index and index-to-onehot functions.
- Sub-module rr_pick16, combinational:
  - Inputs: REQ, PTR. Outputs: pick index and found flag.
  - Implemented as masked priority encode (REQ & mask≥PTR) with fallback to unmasked priority encode.
  - Its found flag is the ANY_REQ term.
- Top: state register, PTR, CNT, output registers.

Test Plan:
- Reset then REQ=16'h0000 for 10 cycles → GNT=0, GNT_VLD=0, ANY_REQ=0 throughout. Assert RST during a grant → GNT=0 at the next edge, PTR back to 0.
- Single requester: REQ=16'h0020 at cycle 5, held 4 cycles → GNT=16'h0020 and GNT_ID=5 from cycle 6. Drop REQ → GNT=0 one cycle later, PTR=6.
- Back-to-back handoff: REQ=16'h8001 with PTR=0 → grant 0. Drop bit 0 → grant 15 on the very next edge, with no GNT=0 cycle. Then PTR=0.
- Preemption with MAX_HOLD=4: REQ=16'h0003 both held → 0 granted for 4 cycles, then 1 for 4, then 0, repeating. With LOCK=1 while 0 owns → 0 keeps the grant indefinitely; CNT saturates at 4.
- Full rotation with MAX_HOLD=1: REQ=16'hFFFF → GNT_ID sequence 0..15, 0 at one per cycle. Check one-hot, GNT_VLD and GNT_ID consistency every cycle.
- Wrap-around: PTR=14 via prior grant of 13, then REQ=16'h0005 → grant 0 (not 2), then PTR=1.
